// File: rtl/motor_ctrl_pkg.sv
// Shared types and constants for the motor velocity command path.
package motor_ctrl_pkg;

  localparam int unsigned BAND_WIDTH = 32;
  // Widest hold duration the command struct can carry; narrower ports zero-extend into it.
  localparam int unsigned DUR_FIELD_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRamp,
    StHold,
    StStop
  } seq_state_e;

  typedef struct packed {
    logic signed [BAND_WIDTH-1:0]  target;
    logic [DUR_FIELD_WIDTH-1:0]    duration;
  } motor_cmd_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate strobe: one-cycle tick every TICK_CYCLE clocks.
module sample_tick_gen #(
  parameter int unsigned TICK_CYCLE = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CntW = (TICK_CYCLE > 1) ? $clog2(TICK_CYCLE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_CYCLE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntLast);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/motor_ramp_sequencer.sv
// Velocity command sequencer: slews target_rot_v toward each commanded velocity at a bounded
// per-sample step, holds it for the commanded number of samples, and ramps to zero on estop.
module motor_ramp_sequencer
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 100_000_000,
  parameter int unsigned SAMPLING_RATE = 100,
  parameter int unsigned MAX_STEP      = 4,
  parameter int unsigned DUR_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [BAND_WIDTH-1:0] cmd_target,
  input  logic [DUR_WIDTH-1:0]  cmd_duration,
  input  logic                  estop,
  output logic [BAND_WIDTH-1:0] target_rot_v,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned TICK_CYCLE = CLK_FREQ / SAMPLING_RATE;
  localparam int unsigned WideW      = BAND_WIDTH + 1;
  localparam logic signed [WideW-1:0]      StepWide   = WideW'(MAX_STEP);
  localparam logic signed [BAND_WIDTH-1:0] StepNarrow = BAND_WIDTH'(MAX_STEP);

  seq_state_e state_q, state_d;
  motor_cmd_t cmd_q, cmd_d, new_cmd;
  logic [DUR_FIELD_WIDTH-1:0] hold_q, hold_d;
  logic signed [BAND_WIDTH-1:0] rot_q, rot_d;
  logic done_q, done_d;

  logic tick;
  logic accept;
  logic dur_zero;
  logic in_band;
  logic signed [BAND_WIDTH-1:0] ramp_goal;
  logic signed [BAND_WIDTH-1:0] ramp_next;
  logic signed [WideW-1:0]      diff;

  sample_tick_gen #(
    .TICK_CYCLE (TICK_CYCLE)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign new_cmd.target   = cmd_target;
  assign new_cmd.duration = DUR_FIELD_WIDTH'(cmd_duration);

  assign dur_zero  = (cmd_q.duration == '0);
  assign cmd_ready = !rst && !estop &&
                     ((state_q == StIdle) || ((state_q == StHold) && dur_zero));
  assign accept    = cmd_valid && cmd_ready;

  // Difference is taken one bit wider so goals near the signed extremes cannot wrap.
  assign ramp_goal = (state_q == StStop) ? '0 : cmd_q.target;
  assign diff      = {ramp_goal[BAND_WIDTH-1], ramp_goal} - {rot_q[BAND_WIDTH-1], rot_q};
  assign in_band   = (diff >= -StepWide) && (diff <= StepWide);
  assign ramp_next = in_band ? ramp_goal :
                     (diff[WideW-1] ? rot_q - StepNarrow : rot_q + StepNarrow);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    hold_d  = hold_q;
    rot_d   = rot_q;
    done_d  = 1'b0;

    if (estop && (state_q != StStop)) begin
      state_d = StStop;
      cmd_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            cmd_d   = new_cmd;
            state_d = StRamp;
          end
        end
        StRamp: begin
          if (tick) begin
            rot_d = ramp_next;
            if (in_band) begin
              hold_d  = cmd_q.duration;
              state_d = StHold;
            end
          end
        end
        StHold: begin
          if (accept) begin
            cmd_d   = new_cmd;
            state_d = StRamp;
          end else if (tick && !dur_zero) begin
            if (hold_q == DUR_FIELD_WIDTH'(1)) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              hold_d = hold_q - DUR_FIELD_WIDTH'(1);
            end
          end
        end
        StStop: begin
          if (tick) begin
            rot_d = ramp_next;
          end
          if ((rot_q == '0) && !estop) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cmd_q   <= '0;
      hold_q  <= '0;
      rot_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      hold_q  <= hold_d;
      rot_q   <= rot_d;
      done_q  <= done_d;
    end
  end

  assign target_rot_v = rot_q;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Bench for motor_ramp_sequencer: directed scenarios plus random traffic against a
// behavioural model of the command/ramp/hold/stop rules.
module tb_motor_ramp_sequencer;

  localparam int Step    = 4;
  localparam int TickLen = 10;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_target;
  logic [15:0] cmd_duration;
  logic        estop;
  logic [31:0] target_rot_v;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  // Model of the observable behaviour.
  longint m_v, m_goal;
  int     m_dur, m_hold, m_cnt;
  bit     m_moving, m_holding, m_stopping, m_done;

  motor_ramp_sequencer #(
    .CLK_FREQ      (1000),
    .SAMPLING_RATE (100),
    .MAX_STEP      (Step),
    .DUR_WIDTH     (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_target   (cmd_target),
    .cmd_duration (cmd_duration),
    .estop        (estop),
    .target_rot_v (target_rot_v),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic longint approach(input longint cur, input longint goal);
    if ((goal - cur <= Step) && (cur - goal <= Step)) return goal;
    if (goal > cur) return cur + Step;
    return cur - Step;
  endfunction

  function automatic bit model_ready(input bit r, input bit e);
    bit idle;
    idle = !m_moving && !m_holding && !m_stopping;
    return !r && !e && (idle || (m_holding && m_dur == 0));
  endfunction

  task automatic model_reset();
    m_v = 0; m_goal = 0; m_dur = 0; m_hold = 0; m_cnt = 0;
    m_moving = 0; m_holding = 0; m_stopping = 0; m_done = 0;
  endtask

  task automatic model_edge(input bit r, input bit e, input bit v, input longint t,
                            input int d);
    bit     tk, rdy;
    longint v_old;
    tk  = (m_cnt == TickLen - 1);
    rdy = model_ready(r, e);
    m_done = 0;
    if (r) begin
      model_reset();
      return;
    end
    m_cnt = (m_cnt + 1) % TickLen;
    v_old = m_v;
    if (e && !m_stopping) begin
      m_stopping = 1; m_moving = 0; m_holding = 0;
    end else if (m_stopping) begin
      if (tk) m_v = approach(m_v, 0);
      if (v_old == 0 && !e) m_stopping = 0;
    end else if (v && rdy) begin
      m_goal = t; m_dur = d; m_moving = 1; m_holding = 0;
    end else if (m_moving) begin
      if (tk) begin
        m_v = approach(m_v, m_goal);
        if (m_v == m_goal) begin
          m_moving = 0; m_holding = 1; m_hold = m_dur;
        end
      end
    end else if (m_holding && m_dur != 0 && tk) begin
      if (m_hold == 1) begin
        m_done = 1; m_holding = 0;
      end else begin
        m_hold--;
      end
    end
  endtask

  task automatic run_cycle(input bit r, input bit e, input bit v, input longint t,
                           input int d);
    @(negedge clk);
    rst          = r;
    estop        = e;
    cmd_valid    = v;
    cmd_target   = t[31:0];
    cmd_duration = d[15:0];
    #1;
    check_eq("cmd_ready", cmd_ready, model_ready(r, e));
    model_edge(r, e, v, t, d);
    @(posedge clk);
    #1;
    check_eq("target_rot_v", $signed(target_rot_v), m_v);
    check_eq("busy", busy, m_moving || m_holding || m_stopping);
    check_eq("done", done, m_done);
  endtask

  int     done_seen;
  int     estop_left;
  bit     found;
  bit     rr, vv;
  longint tt;
  int     dd;

  initial begin
    rst = 1'b1; estop = 1'b0; cmd_valid = 1'b0; cmd_target = '0; cmd_duration = '0;
    model_reset();

    // Reset and release.
    repeat (3) run_cycle(1, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0);
    check_eq("t1_rot", $signed(target_rot_v), 0);
    check_eq("t1_busy", busy, 0);
    check_eq("t1_ready", cmd_ready, 1);

    // Finite hold: 4, 8, 10 then done after two more ticks.
    done_seen = 0;
    run_cycle(0, 0, 1, 10, 2);
    for (int i = 0; i < 70; i++) begin
      run_cycle(0, 0, 0, 0, 0);
      done_seen += int'(done);
    end
    check_eq("t2_done_pulses", done_seen, 1);
    check_eq("t2_rot", $signed(target_rot_v), 10);
    check_eq("t2_busy", busy, 0);

    // Indefinite hold, then retarget from HOLD.
    run_cycle(0, 0, 1, -6, 0);
    repeat (60) run_cycle(0, 0, 0, 0, 0);
    check_eq("t3_rot", $signed(target_rot_v), -6);
    check_eq("t3_busy", busy, 1);
    check_eq("t3_ready", cmd_ready, 1);
    run_cycle(0, 0, 1, 0, 0);
    repeat (30) run_cycle(0, 0, 0, 0, 0);
    check_eq("t3_rot0", $signed(target_rot_v), 0);

    // Emergency stop mid-ramp.
    run_cycle(0, 0, 1, 20, 0);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      run_cycle(0, 0, 0, 0, 0);
      if ($signed(target_rot_v) == 8) found = 1;
    end
    check_eq("t4_reach8", found, 1);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      run_cycle(0, 1, 1, 33, 1);
      done_seen += int'(done);
    end
    check_eq("t4_no_done", done_seen, 0);
    check_eq("t4_rot0", $signed(target_rot_v), 0);
    check_eq("t4_busy_stop", busy, 1);
    repeat (2) run_cycle(0, 0, 0, 0, 0);
    check_eq("t4_idle", busy, 0);
    check_eq("t4_ready", cmd_ready, 1);

    // estop wins over a simultaneous command.
    run_cycle(0, 1, 1, 50, 3);
    check_eq("t5_busy", busy, 1);
    repeat (30) run_cycle(0, 0, 0, 0, 0);
    check_eq("t5_rot", $signed(target_rot_v), 0);
    check_eq("t5_idle", busy, 0);

    // Extreme negative goal, then reset mid-ramp.
    run_cycle(0, 0, 1, -2147483646, 5);
    repeat (35) run_cycle(0, 0, 0, 0, 0);
    check_eq("t6_neg", target_rot_v[31], 1);
    run_cycle(1, 0, 0, 0, 0);
    check_eq("t6_rst_rot", $signed(target_rot_v), 0);
    check_eq("t6_rst_busy", busy, 0);

    // Random traffic.
    estop_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (estop_left > 0) estop_left--;
      else if ($urandom_range(0, 299) == 0) estop_left = int'($urandom_range(1, 40));
      rr = ($urandom_range(0, 999) == 0);
      vv = ($urandom_range(0, 5) == 0);
      tt = longint'($urandom_range(0, 120)) - 60;
      dd = int'($urandom_range(0, 4));
      run_cycle(rr, estop_left > 0, vv, tt, dd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
